// File: rtl/relay_ctrl_pkg.sv
// Shared constants for the relay-machine control sequencer: phase indices,
// register indices, opcode match patterns and the sequencer state encoding.
package relay_ctrl_pkg;

    localparam int PHASE_W = 5;
    typedef logic [PHASE_W-1:0] phase_t;

    // Letter P is not a phase; Q..T follow O directly.
    localparam phase_t P_A = 5'd0,  P_B = 5'd1,  P_C = 5'd2,  P_D = 5'd3;
    localparam phase_t P_E = 5'd4,  P_F = 5'd5,  P_G = 5'd6,  P_H = 5'd7;
    localparam phase_t P_I = 5'd8,  P_J = 5'd9,  P_K = 5'd10, P_L = 5'd11;
    localparam phase_t P_M = 5'd12, P_N = 5'd13, P_O = 5'd14, P_Q = 5'd15;
    localparam phase_t P_R = 5'd16, P_S = 5'd17, P_T = 5'd18;

    localparam logic [2:0] R_A = 3'd0, R_B = 3'd1, R_C = 3'd2, R_D = 3'd3;
    localparam logic [2:0] R_M1 = 3'd4, R_M2 = 3'd5, R_X = 3'd6, R_Y = 3'd7;

    localparam logic [7:0] MOV_MASK   = 8'hC0, MOV_VAL   = 8'h00;
    localparam logic [7:0] ALU_MASK   = 8'hF0, ALU_VAL   = 8'h80;
    localparam logic [7:0] LOAD_MASK  = 8'hFC, LOAD_VAL  = 8'h90;
    localparam logic [7:0] STORE_MASK = 8'hFC, STORE_VAL = 8'h98;
    localparam logic [7:0] INCXY_VAL  = 8'hB0;
    localparam logic [7:0] GOTO_MASK  = 8'hC0, GOTO_VAL  = 8'hC0;
    localparam logic [7:0] HALT_VAL   = 8'hAE;

    localparam phase_t LAST_SHORT = P_H;
    localparam phase_t LAST_MED   = P_L;
    localparam phase_t LAST_LONG  = P_T;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    typedef enum logic [2:0] {
        OP_MOV, OP_ALU, OP_LOAD, OP_STORE, OP_INCXY, OP_GOTO, OP_HALT, OP_ILL
    } op_t;

    function automatic op_t op_class(input logic [7:0] inst);
        if ((inst & MOV_MASK) == MOV_VAL)     return OP_MOV;
        if ((inst & GOTO_MASK) == GOTO_VAL)   return OP_GOTO;
        if ((inst & ALU_MASK) == ALU_VAL)     return OP_ALU;
        if ((inst & LOAD_MASK) == LOAD_VAL)   return OP_LOAD;
        if ((inst & STORE_MASK) == STORE_VAL) return OP_STORE;
        if (inst == INCXY_VAL)                return OP_INCXY;
        if (inst == HALT_VAL)                 return OP_HALT;
        return OP_ILL;
    endfunction

    function automatic phase_t last_phase(input op_t op);
        case (op)
            OP_LOAD, OP_STORE, OP_INCXY: return LAST_MED;
            OP_GOTO:                     return LAST_LONG;
            default:                     return LAST_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Phase pacing: a per-phase divider, the phase index and its one-hot image
// (bit NUM_PHASES-1 = pA). Held at pA with the divider cleared while disabled.
module phase_counter
    import relay_ctrl_pkg::*;
#(
    parameter int NUM_PHASES       = 19,
    parameter int CYCLES_PER_PHASE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wrap,
    output phase_t                phase,
    output logic                  advance,
    output logic [NUM_PHASES-1:0] onehot
);

    logic [7:0] div;

    assign advance = enable && (div == 8'(CYCLES_PER_PHASE - 1));

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div   <= '0;
            phase <= P_A;
        end else if (advance) begin
            div   <= '0;
            phase <= wrap ? P_A : phase + 5'd1;
        end else begin
            div <= div + 8'd1;
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            onehot[NUM_PHASES-1-i] = enable && (phase == PHASE_W'(i));
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Relay-machine control source: IDLE/RUN/HALTED sequencing over phases pA..pT
// and decode of the INST register into datapath strobes for the current phase.
module ctrl_sequencer
    import relay_ctrl_pkg::*;
#(
    parameter int NUM_PHASES       = 19,
    parameter int CYCLES_PER_PHASE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [7:0]            inst_out,
    output logic [NUM_PHASES-1:0] fsm_out,
    output logic [7:0]            ld_reg,
    output logic [7:0]            sel_reg,
    output logic                  ld_XY,
    output logic                  sel_XY,
    output logic                  sel_M,
    output logic                  ld_J1,
    output logic                  ld_J2,
    output logic                  sel_J,
    output logic                  ld_INST,
    output logic                  ld_PC,
    output logic                  sel_PC,
    output logic                  ld_INC,
    output logic                  sel_INC,
    output logic                  ld_CCR,
    output logic                  f1,
    output logic                  f2,
    output logic                  f3,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  bus_to_mem,
    output logic                  halted,
    output logic                  illegal
);

    state_t state;
    phase_t phase;
    logic   advance;
    logic   running;
    logic   at_last;
    op_t    op;

    assign op      = op_class(inst_out);
    assign at_last = (phase == last_phase(op));
    assign running = (state == RUN);

    phase_counter #(
        .NUM_PHASES      (NUM_PHASES),
        .CYCLES_PER_PHASE(CYCLES_PER_PHASE)
    ) u_phase (
        .clk    (clk),
        .reset  (reset),
        .enable (running),
        .wrap   (at_last),
        .phase  (phase),
        .advance(advance),
        .onehot (fsm_out)
    );

    // run is only consulted at the instruction boundary, so dropping it
    // mid-instruction still lets the instruction finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            halted <= 1'b0;
        end else begin
            case (state)
                IDLE: if (run) state <= RUN;
                RUN: begin
                    if (advance && at_last) begin
                        if (op == OP_HALT) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else if (!run) begin
                            state <= IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic logic in_rng(input phase_t p, input phase_t lo, input phase_t hi);
        return (p >= lo) && (p <= hi);
    endfunction

    always_comb begin
        ld_reg = '0;   sel_reg = '0;
        ld_XY = 1'b0;  sel_XY = 1'b0;  sel_M = 1'b0;
        ld_J1 = 1'b0;  ld_J2 = 1'b0;   sel_J = 1'b0;
        ld_INST = 1'b0; ld_PC = 1'b0;  sel_PC = 1'b0;
        ld_INC = 1'b0; sel_INC = 1'b0; ld_CCR = 1'b0;
        f1 = 1'b0;     f2 = 1'b0;      f3 = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; bus_to_mem = 1'b0;
        illegal = 1'b0;
        if (running) begin
            if (phase <= P_C) begin sel_PC = 1'b1; mem_read = 1'b1; end
            if (phase == P_B) begin ld_INST = 1'b1; ld_INC = 1'b1; end
            if (phase == P_D) begin sel_INC = 1'b1; ld_PC = 1'b1; end
            // The instruction register is only trusted once fetch is over.
            if (phase >= P_E) begin
                case (op)
                    OP_MOV: begin
                        if (in_rng(phase, P_E, P_G)) sel_reg[inst_out[2:0]] = 1'b1;
                        if (phase == P_F) ld_reg[inst_out[5:3]] = 1'b1;
                    end
                    OP_ALU: begin
                        if (in_rng(phase, P_E, P_G)) {f1, f2, f3} = inst_out[2:0];
                        if (phase == P_F) begin
                            ld_reg[inst_out[3] ? R_D : R_A] = 1'b1;
                            ld_CCR = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        if (in_rng(phase, P_E, P_K)) begin sel_M = 1'b1; mem_read = 1'b1; end
                        if (phase == P_H) ld_reg[{1'b0, inst_out[1:0]}] = 1'b1;
                    end
                    OP_STORE: begin
                        if (in_rng(phase, P_E, P_K)) begin
                            sel_M = 1'b1;
                            sel_reg[{1'b0, inst_out[1:0]}] = 1'b1;
                        end
                        if (in_rng(phase, P_F, P_J)) bus_to_mem = 1'b1;
                        if (phase == P_H) mem_write = 1'b1;
                    end
                    OP_INCXY: begin
                        if (in_rng(phase, P_E, P_G)) sel_XY = 1'b1;
                        if (phase == P_F) ld_INC = 1'b1;
                        if (in_rng(phase, P_H, P_J)) sel_INC = 1'b1;
                        if (phase == P_I) ld_XY = 1'b1;
                    end
                    OP_GOTO: begin
                        if (in_rng(phase, P_E, P_G) || in_rng(phase, P_I, P_K)) begin
                            sel_PC = 1'b1; mem_read = 1'b1;
                        end
                        if (phase == P_F) begin ld_J1 = 1'b1; ld_INC = 1'b1; end
                        if (phase == P_J) begin ld_J2 = 1'b1; ld_INC = 1'b1; end
                        if (phase == P_H || phase == P_L) begin sel_INC = 1'b1; ld_PC = 1'b1; end
                        if (in_rng(phase, P_M, P_O)) sel_J = 1'b1;
                        if (phase == P_N) ld_PC = 1'b1;
                    end
                    OP_ILL: if (phase == P_H) illegal = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: per-phase control expectations from a spec table,
// queued per instruction and compared every clock on two instances (1 and 3 clk/phase).
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [7:0] inst;

    always #5 clk = ~clk;

    logic [18:0] fsm_a, fsm_b;
    logic [7:0]  ldr_a, selr_a, ldr_b, selr_b;
    logic        halted_a, halted_b;
    wire  [18:0] sb_a, sb_b;

    // Single-bit strobe positions inside sb_*
    localparam logic [34:0] C_LD_XY = 35'h1 << 18, C_SEL_XY = 35'h1 << 17, C_SEL_M = 35'h1 << 16;
    localparam logic [34:0] C_LD_J1 = 35'h1 << 15, C_LD_J2 = 35'h1 << 14, C_SEL_J = 35'h1 << 13;
    localparam logic [34:0] C_LD_INST = 35'h1 << 12, C_LD_PC = 35'h1 << 11, C_SEL_PC = 35'h1 << 10;
    localparam logic [34:0] C_LD_INC = 35'h1 << 9, C_SEL_INC = 35'h1 << 8, C_LD_CCR = 35'h1 << 7;
    localparam logic [34:0] C_F1 = 35'h1 << 6, C_F2 = 35'h1 << 5, C_F3 = 35'h1 << 4;
    localparam logic [34:0] C_MRD = 35'h1 << 3, C_MWR = 35'h1 << 2, C_B2M = 35'h1 << 1, C_ILL = 35'h1;

    localparam int PA = 0, PB = 1, PC = 2, PD = 3, PE = 4, PF = 5, PG = 6, PH = 7;
    localparam int PI = 8, PJ = 9, PK = 10, PL = 11, PM = 12, PN = 13, PO = 14, PT = 18;

    ctrl_sequencer #(.NUM_PHASES(19), .CYCLES_PER_PHASE(1)) dut_a (
        .clk(clk), .reset(reset), .run(run), .inst_out(inst), .fsm_out(fsm_a),
        .ld_reg(ldr_a), .sel_reg(selr_a),
        .ld_XY(sb_a[18]), .sel_XY(sb_a[17]), .sel_M(sb_a[16]),
        .ld_J1(sb_a[15]), .ld_J2(sb_a[14]), .sel_J(sb_a[13]),
        .ld_INST(sb_a[12]), .ld_PC(sb_a[11]), .sel_PC(sb_a[10]),
        .ld_INC(sb_a[9]), .sel_INC(sb_a[8]), .ld_CCR(sb_a[7]),
        .f1(sb_a[6]), .f2(sb_a[5]), .f3(sb_a[4]),
        .mem_read(sb_a[3]), .mem_write(sb_a[2]), .bus_to_mem(sb_a[1]),
        .halted(halted_a), .illegal(sb_a[0])
    );

    ctrl_sequencer #(.NUM_PHASES(19), .CYCLES_PER_PHASE(3)) dut_b (
        .clk(clk), .reset(reset), .run(run), .inst_out(inst), .fsm_out(fsm_b),
        .ld_reg(ldr_b), .sel_reg(selr_b),
        .ld_XY(sb_b[18]), .sel_XY(sb_b[17]), .sel_M(sb_b[16]),
        .ld_J1(sb_b[15]), .ld_J2(sb_b[14]), .sel_J(sb_b[13]),
        .ld_INST(sb_b[12]), .ld_PC(sb_b[11]), .sel_PC(sb_b[10]),
        .ld_INC(sb_b[9]), .sel_INC(sb_b[8]), .ld_CCR(sb_b[7]),
        .f1(sb_b[6]), .f2(sb_b[5]), .f3(sb_b[4]),
        .mem_read(sb_b[3]), .mem_write(sb_b[2]), .bus_to_mem(sb_b[1]),
        .halted(halted_b), .illegal(sb_b[0])
    );

    typedef struct {
        logic        any;
        logic [7:0]  inst;
        int          lo;
        int          hi;
        logic [34:0] val;
    } vec_t;

    typedef struct {
        logic [18:0] fsm;
        logic [34:0] ctl;
        logic        halt;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [34:0] regs(input logic [7:0] ld, input logic [7:0] sel);
        return {ld, sel, 19'h0};
    endfunction

    function automatic void add(input logic any, input logic [7:0] i, input int lo,
                                input int hi, input logic [34:0] val);
        vec_t e;
        e.any = any; e.inst = i; e.lo = lo; e.hi = hi; e.val = val;
        tbl.push_back(e);
    endfunction

    function automatic logic [34:0] exp_ctl(input logic [7:0] i, input int p);
        logic [34:0] v = '0;
        foreach (tbl[k])
            if ((tbl[k].any || tbl[k].inst == i) && p >= tbl[k].lo && p <= tbl[k].hi)
                v |= tbl[k].val;
        return v;
    endfunction

    function automatic int last_of(input logic [7:0] i);
        case (i)
            8'h92, 8'h9B, 8'hB0: return PL;
            8'hC0:               return PT;
            default:             return PH;
        endcase
    endfunction

    task automatic push_instr(input logic [7:0] i, input int reps);
        exp_t x;
        for (int p = 0; p <= last_of(i); p++)
            for (int r = 0; r < reps; r++) begin
                x.fsm = 19'h40000 >> p; x.ctl = exp_ctl(i, p); x.halt = 1'b0;
                sbq.push_back(x);
            end
    endtask

    task automatic push_idle(input logic h, input int n);
        exp_t x;
        x.fsm = '0; x.ctl = '0; x.halt = h;
        for (int k = 0; k < n; k++) sbq.push_back(x);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check(input bit use_b, input string name);
        exp_t x;
        n_checks++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got output with no expectation", name);
            return;
        end
        n_checks--;
        x = sbq.pop_front();
        if (!use_b) begin
            cmp({name, ".fsm_out"}, 64'(fsm_a), 64'(x.fsm));
            cmp({name, ".ctl"},     64'({ldr_a, selr_a, sb_a}), 64'(x.ctl));
            cmp({name, ".halted"},  64'(halted_a), 64'(x.halt));
        end else begin
            cmp({name, ".fsm_out"}, 64'(fsm_b), 64'(x.fsm));
            cmp({name, ".ctl"},     64'({ldr_b, selr_b, sb_b}), 64'(x.ctl));
            cmp({name, ".halted"},  64'(halted_b), 64'(x.halt));
        end
    endtask

    logic [7:0] prog [9] = '{8'h0A, 8'h85, 8'h8B, 8'h92, 8'h9B, 8'hB0, 8'hC0, 8'hA0, 8'h3F};

    initial begin
        // Fetch, common to all opcodes
        add(1, 8'h00, PA, PC, C_SEL_PC | C_MRD);
        add(1, 8'h00, PB, PB, C_LD_INST | C_LD_INC);
        add(1, 8'h00, PD, PD, C_SEL_INC | C_LD_PC);
        // MOV B<-C and MOV Y<-Y
        add(0, 8'h0A, PE, PG, regs(8'h00, 8'h04));
        add(0, 8'h0A, PF, PF, regs(8'h02, 8'h00));
        add(0, 8'h3F, PE, PG, regs(8'h00, 8'h80));
        add(0, 8'h3F, PF, PF, regs(8'h80, 8'h00));
        // ALU r=0 f=101, ALU r=1 f=011
        add(0, 8'h85, PE, PG, C_F1 | C_F3);
        add(0, 8'h85, PF, PF, regs(8'h01, 8'h00) | C_LD_CCR);
        add(0, 8'h8B, PE, PG, C_F2 | C_F3);
        add(0, 8'h8B, PF, PF, regs(8'h08, 8'h00) | C_LD_CCR);
        // LOAD C
        add(0, 8'h92, PE, PK, C_SEL_M | C_MRD);
        add(0, 8'h92, PH, PH, regs(8'h04, 8'h00));
        // STORE D
        add(0, 8'h9B, PE, PK, C_SEL_M | regs(8'h00, 8'h08));
        add(0, 8'h9B, PF, PJ, C_B2M);
        add(0, 8'h9B, PH, PH, C_MWR);
        // INCXY
        add(0, 8'hB0, PE, PG, C_SEL_XY);
        add(0, 8'hB0, PF, PF, C_LD_INC);
        add(0, 8'hB0, PH, PJ, C_SEL_INC);
        add(0, 8'hB0, PI, PI, C_LD_XY);
        // GOTO
        add(0, 8'hC0, PE, PG, C_SEL_PC | C_MRD);
        add(0, 8'hC0, PF, PF, C_LD_J1 | C_LD_INC);
        add(0, 8'hC0, PH, PH, C_SEL_INC | C_LD_PC);
        add(0, 8'hC0, PI, PK, C_SEL_PC | C_MRD);
        add(0, 8'hC0, PJ, PJ, C_LD_J2 | C_LD_INC);
        add(0, 8'hC0, PL, PL, C_SEL_INC | C_LD_PC);
        add(0, 8'hC0, PM, PO, C_SEL_J);
        add(0, 8'hC0, PN, PN, C_LD_PC);
        // Undefined opcode
        add(0, 8'hA0, PH, PH, C_ILL);

        reset = 1'b1; run = 1'b0; inst = 8'h00;
        repeat (3) @(negedge clk);
        push_idle(0, 1); check(0, "reset_a");
        push_idle(0, 1); check(1, "reset_b");

        // Back-to-back program, one clock per phase
        reset = 1'b0;
        @(negedge clk);
        inst = prog[0]; run = 1'b1;
        @(negedge clk);
        foreach (prog[i]) begin
            inst = prog[i];
            push_instr(prog[i], 1);
            for (int p = 0; p <= last_of(prog[i]); p++) begin
                check(0, $sformatf("inst%02h_p%0d", prog[i], p));
                @(negedge clk);
            end
        end

        // HALT: finishes pH, then sticks regardless of run
        inst = 8'hAE;
        push_instr(8'hAE, 1);
        for (int p = 0; p <= PH; p++) begin
            check(0, $sformatf("halt_p%0d", p));
            @(negedge clk);
        end
        push_idle(1, 6);
        for (int k = 0; k < 6; k++) begin
            if (k == 2) run = 1'b0;
            if (k == 4) run = 1'b1;
            check(0, $sformatf("halted_k%0d", k));
            @(negedge clk);
        end
        reset = 1'b1; run = 1'b0;
        @(negedge clk);
        push_idle(0, 1); check(0, "halt_cleared");

        // Three clocks per phase; run dropped at pC, instruction still completes
        reset = 1'b0; inst = 8'h0A; run = 1'b1;
        @(negedge clk);
        push_instr(8'h0A, 3);
        for (int c = 0; c < 24; c++) begin
            if (c == 6) run = 1'b0;
            check(1, $sformatf("slow_c%0d", c));
            @(negedge clk);
        end
        push_idle(0, 3);
        for (int k = 0; k < 3; k++) begin
            check(1, $sformatf("slow_idle%0d", k));
            @(negedge clk);
        end

        // Reset in the middle of pF aborts the instruction
        run = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            exp_t x;
            x.fsm = 19'h40000 >> (c / 3); x.ctl = exp_ctl(8'h0A, c / 3); x.halt = 1'b0;
            sbq.push_back(x);
            check(1, $sformatf("abort_c%0d", c));
            if (c == 15) reset = 1'b1;
            @(negedge clk);
        end
        push_idle(0, 1); check(1, "abort_reset");

        if (sbq.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Control-signal source for the relay machine: a phase sequencer plus an instruction decoder.
- Steps one-hot through phases pA..pT (no pP) and decodes the current instruction into the register load/select, ALU function and memory strobes.
- The LED display bus and every datapath register consume these signals.
- Sits between the INST register (input) and the datapath / LED bus (outputs).

Parameters:
- NUM_PHASES, 19, phase count pA..pT excluding P; fixes the fsm_out width.
- CYCLES_PER_PHASE, 1, clk cycles each phase is held (relay pacing); legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- run  input  1  level; 1 = execute continuously, 0 = stop at the next instruction boundary
- inst_out  input  8  INST register contents
- fsm_out  output  19  one-hot phase; bit18 = pA … bit0 = pT
- ld_reg  output  8  load strobes; index 0..7 = A,B,C,D,M1,M2,X,Y
- sel_reg  output  8  bus selects, same index order
- ld_XY, sel_XY, sel_M  output  1 each  16-bit XY load/select, M1:M2 address select
- ld_J1, ld_J2, sel_J  output  1 each  jump register controls
- ld_INST, ld_PC, sel_PC, ld_INC, sel_INC, ld_CCR  output  1 each
- f1, f2, f3  output  1 each  ALU function = inst_out[2:0]
- mem_read, mem_write, bus_to_mem  output  1 each
- halted  output  1  HALT executed
- illegal  output  1  pulse at pH of an undefined opcode

Behaviour:
- Reset is synchronous, active-high, and aborts any instruction: state IDLE, phase cleared, divider 0, all outputs 0, halted 0.
- States and transitions:
  - IDLE: fsm_out = 0. If run = 1 → RUN at pA on the next clk.
  - RUN: phase advances when the divider reaches CYCLES_PER_PHASE-1; the divider then clears.
    - At the instruction's last phase: HALT → HALTED; else run = 0 → IDLE; else → pA.
    - run dropping mid-instruction never truncates it.
  - HALTED: fsm_out = 0, halted = 1; left only via reset.
- All control outputs are a combinational function of (state, phase, inst_out), constant for the whole phase. All are 0 outside RUN.
- Fetch, identical for every opcode:
  - pA..pC: sel_PC, mem_read.
  - pB: ld_INST, ld_INC.
  - pD: sel_INC, ld_PC.
- inst_out is decoded only from pE onward.
- MOV8, 00dddsss, last phase pH: sel_reg[sss] pE..pG; ld_reg[ddd] pF. d = s is legal.
- ALU, 1000rfff, last phase pH: f1..f3 = fff pE..pG; pF ld_reg[A if r=0 else D] and ld_CCR.
- LOAD, 100100rr, last phase pL: pE..pK sel_M, mem_read; pH ld_reg[rr] (rr 0..3 = A..D).
- STORE, 100110rr, last phase pL: pE..pK sel_M, sel_reg[rr]; pF..pJ bus_to_mem; pH mem_write.
- INCXY, 10110000, last phase pL: pE..pG sel_XY; pF ld_INC; pH..pJ sel_INC; pI ld_XY.
- GOTO, 11xxxxxx, last phase pT:
  - pE..pG sel_PC, mem_read; pF ld_J1, ld_INC.
  - pH sel_INC, ld_PC.
  - pI..pK sel_PC, mem_read; pJ ld_J2, ld_INC.
  - pL sel_INC, ld_PC.
  - pM..pO sel_J; pN ld_PC.
  - pQ..pT idle.
- HALT, 10101110: NOP body, last phase pH.
- Any other opcode: NOP, last phase pH, illegal = 1 during pH.
- fsm_out is always exactly one-hot in RUN and all-zero otherwise.
- Divider wraps only at phase advance.

Decomposition:
- Shared package relay_ctrl_pkg:
  - phase index constants P_A..P_T (P_A = 0 … P_T = 18);
  - register index constants R_A..R_Y;
  - opcode match masks/values;
  - last-phase constants LAST_SHORT = P_H, LAST_MED = P_L, LAST_LONG = P_T;
  - state enum {IDLE, RUN, HALTED}.
- One sub-module, phase_counter: divider plus phase index plus one-hot encode, with an advance/wrap interface. Decode stays in ctrl_sequencer.

Test Plan:
- Reset, then run = 1, inst_out = 0x0A (MOV B←C) → fsm_out 0x40000 on the first RUN cycle; sel_reg = 0x04 pE..pG; ld_reg = 0x02 at pF only; back at pA after 8 clocks.
- inst_out = 0x85 (ALU, r = 0, f = 101) → f1 = 1, f2 = 0, f3 = 1 pE..pG; ld_reg = 0x01 and ld_CCR at pF; 8 phases.
- inst_out = 0x92 (LOAD C) → ld_reg = 0x04 at pH, mem_read pE..pK, 12 phases. Then 0x9B (STORE D) → mem_write only at pH, bus_to_mem pF..pJ.
- inst_out = 0xC0 (GOTO) → ld_J1 at pF, ld_J2 at pJ, ld_PC at pD, pH, pL, pN; 19 phases before pA recurs.
- inst_out = 0xAE (HALT) → halted = 1 and fsm_out = 0 after pH; run toggling has no effect; reset clears halted.
- CYCLES_PER_PHASE = 3, run deasserted at pC of 0x0A → each phase held 3 clocks, instruction completes through pH (24 clocks), then IDLE. Reset asserted at pF → all outputs 0 on the next clock.
